// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the processor data-memory path.
// Contents:
//   F3_*          RV32I load/store width/sign codes
//   dmem_state_t  control states of the data-memory stage
//   access_size_t effective access width after funct3 decoding
//   access_size   decodes funct3 into an access width
//   misaligned_at true when a byte offset is illegal for the access width
package proc_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } dmem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } access_size_t;

  // Unlisted funct3 codes fall back to a full word for both loads and stores.
  function automatic access_size_t access_size(input logic is_load,
                                               input logic [2:0] funct3);
    access_size_t sz;
    sz = SZ_W;
    if (is_load) begin
      case (funct3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end else begin
      case (funct3)
        F3_B:    sz = SZ_B;
        F3_H:    sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic misaligned_at(input access_size_t sz,
                                         input logic [1:0] offset);
    logic bad;
    case (sz)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offset[0];
      default: bad = (offset != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load-data extraction and extension.
// Ports:
//   rdata  in  32  raw word from the data bus
//   addr   in  2   byte offset of the access inside the word
//   funct3 in  3   load width/sign code (unlisted codes behave as LW)
//   value  out 32  right-aligned, sign- or zero-extended result
module load_extend
  import proc_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (funct3)
      F3_B:    value = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    value = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   value = {24'd0, shifted[7:0]};
      F3_HU:   value = {16'd0, shifted[15:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// dmem_access: data-memory pipeline stage.
// Takes one load/store per ex_valid/ex_ready handshake and runs it on a
// word-addressed req/ack bus, then reports load results to writeback.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid / ex_ready        request handshake from execute
//   ex_is_load, ex_is_store    operation kind (both set = load)
//   ex_funct3, ex_addr         width/sign code and byte address
//   ex_store_data, ex_rd       right-aligned store operand, load destination
//   mem_req/we/addr/wdata/wstrb  bus request, held stable until mem_ack
//   mem_ack, mem_rdata         bus completion and read data
//   load_active, next_rd, next_rd_value  one-cycle load result bundle
//   misaligned                 one-cycle pulse for a rejected access
//   busy                       state != IDLE
//   dbg_state                  current control state
//
// Handshakes: a request transfers on a rising edge where ex_valid and
// ex_ready are both high; ex_ready is high exactly when the stage is IDLE.
// On the bus, mem_req stays high with all mem_* outputs frozen until a
// rising edge samples mem_ack high; mem_ack outside REQ is ignored.
module dmem_access
  import proc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [RD_W-1:0] ex_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            load_active,
  output logic [RD_W-1:0] next_rd,
  output logic [XLEN-1:0] next_rd_value,
  output logic            misaligned,
  output logic            busy,
  output dmem_state_t     dbg_state
);

  dmem_state_t     state;
  logic            op_load;
  logic [2:0]      op_funct3;
  logic [1:0]      op_offset;
  logic [RD_W-1:0] op_rd;

  access_size_t    acc_size;
  logic            acc_mem;
  logic            acc_misaligned;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] ext_value;

  assign ex_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Load wins when both kind bits are set, so is_load alone picks the decode.
  assign acc_mem        = ex_is_load | ex_is_store;
  assign acc_size       = access_size(ex_is_load, ex_funct3);
  assign acc_misaligned = misaligned_at(acc_size, ex_addr[1:0]);

  // Narrow stores are replicated on every lane; the strobe selects the
  // lanes the memory actually writes.
  always_comb begin
    st_wdata = ex_store_data;
    st_wstrb = 4'b1111;
    case (acc_size)
      SZ_B: begin
        st_wdata = {4{ex_store_data[7:0]}};
        st_wstrb = 4'b0001 << ex_addr[1:0];
      end
      SZ_H: begin
        st_wdata = {2{ex_store_data[15:0]}};
        st_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = ex_store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .addr   (op_offset),
    .funct3 (op_funct3),
    .value  (ext_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_load       <= 1'b0;
      op_funct3     <= '0;
      op_offset     <= '0;
      op_rd         <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      load_active   <= 1'b0;
      next_rd       <= '0;
      next_rd_value <= '0;
      misaligned    <= 1'b0;
    end else begin
      load_active <= 1'b0;
      misaligned  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && acc_mem) begin
            if (acc_misaligned) begin
              state      <= FAULT;
              misaligned <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= ~ex_is_load;
              mem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
              mem_wdata <= ex_is_load ? '0 : st_wdata;
              mem_wstrb <= ex_is_load ? 4'b0000 : st_wstrb;
              op_load   <= ex_is_load;
              op_funct3 <= ex_funct3;
              op_offset <= ex_addr[1:0];
              op_rd     <= ex_rd;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (op_load) begin
              state         <= RESP;
              load_active   <= 1'b1;
              next_rd       <= op_rd;
              // x0 is hard-wired to zero, so its result is zeroed here.
              next_rd_value <= (op_rd == '0) ? '0 : ext_value;
            end else begin
              state <= IDLE;
            end
          end
        end
        RESP:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed and randomized checks of dmem_access against a
// byte-level reference model of the load/store rules.
module tb_dmem_access;
  import proc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        load_active;
  logic [4:0]  next_rd;
  logic [31:0] next_rd_value;
  logic        misaligned;
  logic        busy;
  dmem_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;
  logic [36:0] exp_q[$];   // {rd, value} of each expected load result

  dmem_access #(.XLEN(32), .RD_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_funct3     (ex_funct3),
    .ex_addr       (ex_addr),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .load_active   (load_active),
    .next_rd       (next_rd),
    .next_rd_value (next_rd_value),
    .misaligned    (misaligned),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (load_active === 1'b1) pulse_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic int eff_size(input bit is_ld, input logic [2:0] f3);
    if (is_ld) begin
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
    end
    if (f3 == 3'b000) return 1;
    if (f3 == 3'b001) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata, input logic [4:0] rd);
    int sz;
    int lo;
    logic [63:0] v;
    sz = eff_size(1'b1, f3);
    lo = int'(addr % 4);
    v = 64'd0;
    if (rd == 5'd0) return 32'd0;
    for (int i = 0; i < sz; i++) v = v | (64'(rdata[8*(lo+i) +: 8]) << (8*i));
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    int lo;
    logic [3:0] s;
    sz = eff_size(1'b0, f3);
    lo = int'(addr % 4);
    s = 4'd0;
    for (int i = 0; i < 4; i++) if (i >= lo && i < lo + sz) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    sz = eff_size(1'b0, f3);
    if (sz == 1) return {4{d[7:0]}};
    if (sz == 2) return {2{d[15:0]}};
    return d;
  endfunction

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_ready();
    int n;
    n = 0;
    while (ex_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", {31'd0, ex_ready}, 32'd1);
  endtask

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input int dly, input logic [31:0] rdata);
    bit is_mem;
    bit mis;
    logic [36:0] e;
    is_mem = ld | st;
    mis = is_mem && ((addr % eff_size(ld, f3)) != 0);
    wait_ready();
    ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_store_data = data; ex_rd = rd; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    ex_addr = $urandom; ex_store_data = $urandom; ex_rd = 5'($urandom);
    ex_funct3 = 3'($urandom);
    if (!is_mem) begin
      check("noop_busy", {31'd0, busy}, 32'd0);
      check("noop_req", {31'd0, mem_req}, 32'd0);
      return;
    end
    if (mis) begin
      check("mis_pulse", {31'd0, misaligned}, 32'd1);
      check("mis_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      check("mis_clear", {31'd0, misaligned}, 32'd0);
      check("mis_req2", {31'd0, mem_req}, 32'd0);
      check("mis_ready", {31'd0, ex_ready}, 32'd1);
      return;
    end
    check("req", {31'd0, mem_req}, 32'd1);
    check("we", {31'd0, mem_we}, {31'd0, ~ld});
    check("addr", mem_addr, addr & 32'hFFFF_FFFC);
    check("wstrb", {28'd0, mem_wstrb}, ld ? 32'd0 : {28'd0, model_wstrb(f3, addr)});
    if (!ld) check("wdata", mem_wdata, model_wdata(f3, data));
    if (ld) begin
      exp_q.push_back({rd, model_load(f3, addr, rdata, rd)});
      exp_pulses++;
    end
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
    end
    if (dly > 0) begin
      check("req_hold", {31'd0, mem_req}, 32'd1);
      check("addr_hold", mem_addr, addr & 32'hFFFF_FFFC);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (ld) begin
      check("load_active", {31'd0, load_active}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("next_rd", {27'd0, next_rd}, {27'd0, e[36:32]});
        check("next_rd_value", next_rd_value, e[31:0]);
      end
      check("req_drop", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      check("pulse_end", {31'd0, load_active}, 32'd0);
      check("ready_after_load", {31'd0, ex_ready}, 32'd1);
    end else begin
      check("store_no_load", {31'd0, load_active}, 32'd0);
      check("store_ready", {31'd0, ex_ready}, 32'd1);
      check("store_req_drop", {31'd0, mem_req}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] rnd;
    int kind;
    int sz;
    logic [2:0] f3;
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 32'd0; ex_store_data = 32'd0; ex_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_load_active", {31'd0, load_active}, 32'd0);
    check("rst_next_rd", {27'd0, next_rd}, 32'd0);
    check("rst_next_rd_value", next_rd_value, 32'd0);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed steps
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF);
    check("lw_value_literal", next_rd_value, 32'hDEADBEEF);
    run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd1, 1, 32'h80FF_0000);
    check("lb_value_literal", next_rd_value, 32'hFFFFFF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd2, 0, 32'h80FF_0000);
    check("lbu_value_literal", next_rd_value, 32'h00000080);
    run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd3, 2, 32'h80FF_0000);
    check("lh_value_literal", next_rd_value, 32'hFFFF80FF);
    run_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd4, 0, 32'h80FF_0000);
    check("lhu_value_literal", next_rd_value, 32'h000080FF);
    run_op(1'b0, 1'b1, 3'b000, 32'h201, 32'hAB, 5'd0, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_5678, 5'd0, 1, 32'h0);
    run_op(1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 5'd0, 2, 32'h0);
    run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd7, 0, 32'h0);
    run_op(1'b0, 1'b1, 3'b001, 32'h301, 32'h5555, 5'd0, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'b000, 32'h3, 32'h0, 5'd8, 0, 32'h0000_007F);
    run_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd0, 1, 32'h0000_1234);
    check("rd0_value_literal", next_rd_value, 32'd0);
    run_op(1'b1, 1'b1, 3'b001, 32'h52, 32'h0, 5'd9, 0, 32'h8001_7FFF);
    run_op(1'b0, 1'b0, 3'b010, 32'h60, 32'h0, 5'd10, 0, 32'h0);
    run_op(1'b1, 1'b0, 3'b111, 32'h70, 32'h0, 5'd11, 0, 32'h1357_9BDF);

    // stray ack while idle
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_ack_busy", {31'd0, busy}, 32'd0);
    check("stray_ack_req", {31'd0, mem_req}, 32'd0);

    // randomized operations
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      sz = eff_size(kind != 0 && kind < 6, f3);
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      rnd = $urandom;
      run_op(kind == 1 || (kind >= 2 && kind <= 5), kind == 1 || kind >= 6, f3, a, rnd,
             5'($urandom), $urandom_range(0, 3), $urandom);
    end

    // reset in the middle of a pending load
    wait_ready();
    ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h500; ex_rd = 5'd12; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    check("rst_mid_req_up", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_drop", {31'd0, mem_req}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ready", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("rst_mid_no_load", {31'd0, load_active}, 32'd0);
    check("rst_mid_idle", {31'd0, busy}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("pulse_count", pulse_cnt, exp_pulses);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access.md
# dmem_access

Data-memory stage of the processor pipeline. Accepts one load or store per handshake from the execute stage and runs it on a word-addressed data-memory bus with a variable-latency req/ack handshake. Store data is placed on byte lanes with a matching strobe. Load data is extracted, sign- or zero-extended, and presented to the writeback stage as a one-cycle `load_active` pulse with `next_rd` / `next_rd_value`. This block produces the load-result bundle that writeback consumes.

## Interface
Parameters:
- `XLEN`, 32, data and address width (only 32 supported)
- `RD_W`, 5, destination register index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  execute stage presents a memory op
- `ex_ready`  out  1  unit can accept; transfer when `ex_valid && ex_ready`
- `ex_is_load`, `ex_is_store`  in  1 each  operation kind
- `ex_funct3`  in  3  RV32I width/sign code
- `ex_addr`  in  XLEN  byte address
- `ex_store_data`  in  XLEN  store operand, right-aligned
- `ex_rd`  in  RD_W  load destination
- `mem_req`  out  1  bus request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  XLEN  word address, `[1:0]` = 0
- `mem_wdata`  out  XLEN  lane-aligned write data
- `mem_wstrb`  out  4  byte enables; 0 on reads
- `mem_ack`  in  1  completes the current request
- `mem_rdata`  in  XLEN  read data, valid with `mem_ack`
- `load_active`  out  1  one-cycle pulse: load result valid
- `next_rd`  out  RD_W  load destination
- `next_rd_value`  out  XLEN  extended load data
- `misaligned`  out  1  one-cycle pulse: access rejected
- `busy`  out  1  state != IDLE

## Operation
- FSM states:
  - **IDLE**: `ex_ready = 1`.
  - On accept of a load or store: latch the operands, go to **REQ**.
  - On accept of a misaligned op: go to **FAULT**.
  - On accept with neither load nor store set: no-op, stay in **IDLE**.
  - **REQ**: `mem_req = 1`. All `mem_*` outputs are held stable until `mem_ack`.
    - On ack, load: register the extended data, go to **RESP**.
    - On ack, store: go to **IDLE**.
  - **RESP**: `load_active = 1` for exactly one cycle, then **IDLE**.
  - **FAULT**: `misaligned = 1` for one cycle, then **IDLE**. No bus access occurs.
- If both `ex_is_load` and `ex_is_store` are set, the op is treated as a load.
- Misaligned cases:
  - halfword access with `addr[0] = 1`
  - word access with `addr[1:0] != 0`
  - Byte accesses are never misaligned.
- funct3 decoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Other codes are treated as LW.
  - Stores: 000 SB, 001 SH, 010 SW. Other codes are treated as SW.
- Store lanes:
  - SB: byte replicated on all 4 lanes; `wstrb = 1 << addr[1:0]`.
  - SH: halfword replicated; `wstrb = 0011` or `1100` by `addr[1]`.
  - SW: `wstrb = 1111`.
- Load extract: shift `mem_rdata` right by `8*addr[1:0]`, take byte or halfword, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- `rd = 0`: the load is performed, `load_active` still pulses, and `next_rd_value` is forced to 0.
- `next_rd` and `next_rd_value` hold their last value outside the pulse. Consumers qualify them with `load_active`.

## Timing
- Reset (async assert): state IDLE. Outputs:
  - `ex_ready = 1`
  - `mem_req = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`, `mem_wstrb = 0`
  - `load_active = 0`, `next_rd = 0`, `next_rd_value = 0`
  - `misaligned = 0`, `busy = 0`
- Reset mid-transaction drops `mem_req` immediately. The pending op is discarded and no `load_active` is produced.
- Accept at edge N → `mem_req` high from cycle N+1. `mem_ack` may arrive in the same cycle `mem_req` rises.
- Load latency: ack sampled at edge M → `load_active` high during cycle M+1. Minimum accept-to-result is 2 cycles.
- Store: ack at edge M → IDLE and `ex_ready = 1` in cycle M+1.
- `mem_ack` while not in REQ is ignored.
- One outstanding op. Back-to-back throughput:
  - 3 cycles per load with zero-wait ack
  - 2 cycles per store with zero-wait ack

## Structure
- Shared package `proc_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`)
  - state enum `dmem_state_t` {IDLE, REQ, RESP, FAULT}
- Combinational sub-module `load_extend`:
  - inputs: `rdata`, `addr[1:0]`, `funct3`
  - output: 32-bit extended value
  - reused by any future cache path
- Store lane/strobe generation stays inline.

## Test plan
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF, rd 5 → `mem_addr` 0x100, `wstrb` 0; one `load_active` pulse, `next_rd` 5, `next_rd_value` 0xDEADBEEF.
- LB and LBU at addr 0x103 with rdata 0x80FF_0000 → values 0xFFFFFF80 and 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB 0xAB to 0x201 with zero-wait ack → `mem_addr` 0x200, `wdata` 0xABABABAB, `wstrb` 0010, `mem_we` 1, no `load_active`. `ex_ready` back 2 cycles after accept.
- LW at 0x102 and SH at 0x301 → `misaligned` pulse one cycle after accept, `mem_req` never asserted.
- LW with rd 0 and rdata 0x1234 → `load_active` pulses with `next_rd_value` 0.
- `rst_n` low during REQ with no ack → `mem_req` 0 immediately, `busy` 0, and no `load_active` after release even if `mem_ack` arrives.
